// File: rtl/signal_control_timed.sv
// Highway/country-road junction controller with one shared cycle timer, minimum greens,
// a country-green timeout that keeps the highway from starving, and all-red in both directions.
module signal_control_timed #(
  parameter int Y2R_DELAY      = 3,
  parameter int R2G_DELAY      = 2,
  parameter int MIN_GREEN      = 4,
  parameter int MAX_CTRY_GREEN = 8,
  parameter int CNT_W          = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       flag,
  output logic [1:0] hwy,
  output logic [1:0] contry,
  output logic [2:0] state,
  output logic       ctry_timeout
);

  localparam logic [2:0] S0 = 3'd0;  // highway green
  localparam logic [2:0] S1 = 3'd1;  // highway yellow
  localparam logic [2:0] S2 = 3'd2;  // all red, towards country
  localparam logic [2:0] S3 = 3'd3;  // country green
  localparam logic [2:0] S4 = 3'd4;  // country yellow
  localparam logic [2:0] S5 = 3'd5;  // all red, towards highway

  localparam logic [1:0] LAMP_R = 2'd0;
  localparam logic [1:0] LAMP_Y = 2'd1;
  localparam logic [1:0] LAMP_G = 2'd2;

  localparam logic [CNT_W-1:0] Y2R_LAST = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] R2G_LAST = CNT_W'(R2G_DELAY - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CTRY_GREEN - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       hwy_q, hwy_d;
  logic [1:0]       contry_q, contry_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S0;
      timer_q   <= '0;
      hwy_q     <= LAMP_G;
      contry_q  <= LAMP_R;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hwy_q     <= hwy_d;
      contry_q  <= contry_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0: if (flag && (timer_q >= MIN_LAST)) state_d = S1;
      S1: if (timer_q == Y2R_LAST) state_d = S2;
      S2: if (timer_q == R2G_LAST) state_d = S3;
      S3: if ((!flag && (timer_q >= MIN_LAST)) || (timer_q == MAX_LAST)) state_d = S4;
      S4: if (timer_q == Y2R_LAST) state_d = S5;
      S5: if (timer_q == R2G_LAST) state_d = S0;
      default: state_d = S0;
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge as state.
  always_comb begin
    hwy_d    = LAMP_R;
    contry_d = LAMP_R;
    case (state_d)
      S0:      hwy_d    = LAMP_G;
      S1:      hwy_d    = LAMP_Y;
      S3:      contry_d = LAMP_G;
      S4:      contry_d = LAMP_Y;
      default: ;
    endcase
    // With flag still high, a country-green exit can only have come from the timeout.
    timeout_d = (state_q == S3) && (state_d == S4) && flag;
    if (state_d != state_q)
      timer_d = '0;
    else if (timer_q == {CNT_W{1'b1}})
      timer_d = timer_q;
    else
      timer_d = timer_q + 1'b1;
  end

  assign hwy          = hwy_q;
  assign contry       = contry_q;
  assign state        = state_q;
  assign ctry_timeout = timeout_q;

endmodule

// File: tb/tb_signal_control_timed.sv
// Scoreboard bench for signal_control_timed: expected per-cycle {timeout,state,hwy,contry}
// words are queued as each scenario is set up and popped as the DUT steps.
module tb_signal_control_timed;
  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       flag  = 1'b0;
  logic       flag2 = 1'b0;
  logic [1:0] hwy, contry, hwy2, contry2;
  logic [2:0] state, state2;
  logic       ctry_timeout, ctry_timeout2;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_v, got;
  logic [63:0] fl;
  logic       reached;

  always #5 clock = ~clock;

  signal_control_timed dut (
    .clock(clock), .clear(clear), .flag(flag),
    .hwy(hwy), .contry(contry), .state(state), .ctry_timeout(ctry_timeout)
  );

  signal_control_timed #(
    .Y2R_DELAY(1), .R2G_DELAY(1), .MIN_GREEN(1), .MAX_CTRY_GREEN(1), .CNT_W(4)
  ) dut_min (
    .clock(clock), .clear(clear), .flag(flag2),
    .hwy(hwy2), .contry(contry2), .state(state2), .ctry_timeout(ctry_timeout2)
  );

  // Lamp table per state: S0 G/R, S1 Y/R, S2 R/R, S3 R/G, S4 R/Y, S5 R/R.
  function automatic logic [7:0] enc(input logic [2:0] st, input logic to);
    logic [1:0] h;
    logic [1:0] c;
    h = 2'd0;
    c = 2'd0;
    case (st)
      3'd0: h = 2'd2;
      3'd1: h = 2'd1;
      3'd3: c = 2'd2;
      3'd4: c = 2'd1;
      default: ;
    endcase
    return {to, st, h, c};
  endfunction

  task automatic push_ph(input logic [2:0] st, input int n, input logic to_first);
    for (int i = 0; i < n; i++) sb.push_back(enc(st, (i == 0) ? to_first : 1'b0));
  endtask

  task automatic do_reset;
    clear = 1'b1;
    flag  = 1'b0;
    flag2 = 1'b0;
    sb.delete();
    repeat (2) @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    flag = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      @(negedge clock);
      if (state == 3'd4) reached = 1'b1;
    end
    @(negedge clock);
    n_cmp++;
    if (state !== 3'd4) begin
      n_mis++;
      $display("FAIL reset_reach_s4: state %0d, want 4", state);
    end
    #2 clear = 1'b1;
    #1;
    got = {ctry_timeout, state, hwy, contry};
    n_cmp++;
    if (got !== enc(3'd0, 1'b0)) begin
      n_mis++;
      $display("FAIL reset_async: got %h, want %h", got, enc(3'd0, 1'b0));
    end
    @(negedge clock);
    got = {ctry_timeout, state, hwy, contry};
    n_cmp++;
    if (got !== enc(3'd0, 1'b0)) begin
      n_mis++;
      $display("FAIL reset_hold: got %h, want %h", got, enc(3'd0, 1'b0));
    end
    clear = 1'b0;
    flag  = 1'b0;
    push_ph(3'd0, 20, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_v = sb.pop_front();
      got = {ctry_timeout, state, hwy, contry};
      n_cmp++;
      if (got !== exp_v) begin
        n_mis++;
        $display("FAIL reset_idle cyc %0d: got %h, want %h", k, got, exp_v);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_basic;
    do_reset();
    fl = 64'h1FF;  // flag high until country green is entered
    push_ph(3'd0, 4, 1'b0); push_ph(3'd1, 3, 1'b0); push_ph(3'd2, 2, 1'b0);
    push_ph(3'd3, 4, 1'b0); push_ph(3'd4, 3, 1'b0); push_ph(3'd5, 2, 1'b0);
    push_ph(3'd0, 3, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_v = sb.pop_front();
      got = {ctry_timeout, state, hwy, contry};
      n_cmp++;
      if (got !== exp_v) begin
        n_mis++;
        $display("FAIL basic cyc %0d: got %h, want %h", k, got, exp_v);
      end
      flag = fl[0];
      fl = fl >> 1;
      @(negedge clock);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    fl = '1;
    for (int r = 0; r < 2; r++) begin
      push_ph(3'd0, 4, 1'b0); push_ph(3'd1, 3, 1'b0); push_ph(3'd2, 2, 1'b0);
      push_ph(3'd3, 8, 1'b0); push_ph(3'd4, 3, 1'b1); push_ph(3'd5, 2, 1'b0);
    end
    push_ph(3'd0, 4, 1'b0); push_ph(3'd1, 1, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_v = sb.pop_front();
      got = {ctry_timeout, state, hwy, contry};
      n_cmp++;
      if (got !== exp_v) begin
        n_mis++;
        $display("FAIL timeout cyc %0d: got %h, want %h", k, got, exp_v);
      end
      flag = fl[0];
      fl = fl >> 1;
      @(negedge clock);
    end
  endtask

  task automatic test_glitch;
    do_reset();
    // Single-cycle pulses inside S1, S2, S4 and S5; flag low through country green.
    fl = 64'h2A0AF;
    push_ph(3'd0, 4, 1'b0); push_ph(3'd1, 3, 1'b0); push_ph(3'd2, 2, 1'b0);
    push_ph(3'd3, 4, 1'b0); push_ph(3'd4, 3, 1'b0); push_ph(3'd5, 2, 1'b0);
    push_ph(3'd0, 6, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_v = sb.pop_front();
      got = {ctry_timeout, state, hwy, contry};
      n_cmp++;
      if (got !== exp_v) begin
        n_mis++;
        $display("FAIL glitch cyc %0d: got %h, want %h", k, got, exp_v);
      end
      flag = fl[0];
      fl = fl >> 1;
      @(negedge clock);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    fl = 64'hFFFF;  // flag falls exactly at the S3 edge where timer reaches 7
    push_ph(3'd0, 4, 1'b0); push_ph(3'd1, 3, 1'b0); push_ph(3'd2, 2, 1'b0);
    push_ph(3'd3, 8, 1'b0); push_ph(3'd4, 3, 1'b0); push_ph(3'd5, 2, 1'b0);
    push_ph(3'd0, 4, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_v = sb.pop_front();
      got = {ctry_timeout, state, hwy, contry};
      n_cmp++;
      if (got !== exp_v) begin
        n_mis++;
        $display("FAIL simultaneous cyc %0d: got %h, want %h", k, got, exp_v);
      end
      flag = fl[0];
      fl = fl >> 1;
      @(negedge clock);
    end
  endtask

  task automatic test_min_params;
    do_reset();
    flag2 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      push_ph(3'd0, 1, 1'b0); push_ph(3'd1, 1, 1'b0); push_ph(3'd2, 1, 1'b0);
      push_ph(3'd3, 1, 1'b0); push_ph(3'd4, 1, 1'b1); push_ph(3'd5, 1, 1'b0);
    end
    push_ph(3'd0, 1, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_v = sb.pop_front();
      got = {ctry_timeout2, state2, hwy2, contry2};
      n_cmp++;
      if (got !== exp_v) begin
        n_mis++;
        $display("FAIL min_params cyc %0d: got %h, want %h", k, got, exp_v);
      end
      n_cmp++;
      if (hwy2 == 2'd3 || contry2 == 2'd3 || state2 > 3'd5 || (hwy2 != 2'd0 && contry2 != 2'd0)) begin
        n_mis++;
        $display("FAIL min_params_legal cyc %0d: hwy %0d contry %0d state %0d", k, hwy2, contry2, state2);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_glitch();
    test_simultaneous();
    test_min_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
